lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum ACCESS-state cycles to wait for mem_ack before aborting; legal range 1..255.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  load/store request from the decode stage; sampled only in IDLE.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RV32I access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 mem_req  output  1  bus request, held high until ack or timeout.
REQ-010 mem_we  output  1  bus write enable.
REQ-011 mem_addr  output  32  word-aligned bus address, {addr[31:2],2'b00}.
REQ-012 mem_wstrb  output  4  byte write strobes; 0000 on loads.
REQ-013 mem_wdata  output  32  lane-replicated store data.
REQ-014 mem_rdata  input  32  bus read word; valid only when mem_ack = 1.
REQ-015 mem_ack  input  1  bus completion, single-cycle pulse.
REQ-016 load_ready  output  1  one-cycle completion pulse for any request; drives the decoder's load_type_in.
REQ-017 busy  output  1  high in ACCESS and DONE.
REQ-018 rdata_out  output  32  aligned, extended load result; held until the next load completes.
REQ-019 err  output  1  one-cycle pulse with load_ready when the access is illegal, misaligned or timed out.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-021 IDLE: req_valid=1 with legal funct3 SHALL register req_we, funct3, addr and wdata, then enter ACCESS on the next edge.
REQ-022 Illegal funct3 (loads 011/110/111, stores anything other than 000/001/010) SHALL go to DONE with err=1, and no bus cycle SHALL be issued.
REQ-023 ACCESS: mem_req=1, with mem_we, mem_addr, mem_wstrb and mem_wdata stable for the whole state.
REQ-024 Strobes SHALL be SB 0001<<addr[1:0]; SH 0011<<{addr[1],1'b0}; SW 1111.
REQ-025 mem_wdata SHALL be SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-026 When mem_ack=1 in ACCESS, a load SHALL register the lane selected by addr[1:0] into rdata_out, sign-extended (B/H) or zero-extended (BU/HU); the state SHALL then go to DONE.
REQ-027 Minimum latency SHALL be 2 cycles: capture edge, then ack in the first ACCESS cycle, then load_ready in DONE.
REQ-028 An 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-029 When the wait counter reaches TIMEOUT_CYCLES with no ack: mem_req SHALL drop, rdata_out SHALL be 0 for a load, err=1, and the state SHALL go to DONE.
REQ-030 An ack arriving in the same cycle the wait counter hits the limit SHALL win; no timeout SHALL be flagged.
REQ-031 DONE: load_ready=1 for exactly one cycle, then return to IDLE; a new request SHALL be accepted no earlier than the cycle after DONE.
REQ-032 mem_ack in IDLE or DONE SHALL be ignored.
REQ-033 req_valid in ACCESS or DONE SHALL be ignored; the requester holds it until load_ready.

Reset
REQ-034 Reset SHALL force state IDLE, wait counter 0, and every output 0, including rdata_out=0.
REQ-035 Reset during ACCESS SHALL drop mem_req immediately and abandon the transaction; no load_ready SHALL follow.

Configuration
REQ-036 Macro LSU_MISALIGN_TRAP_EN defined: a misaligned access (H with addr[0]=1, W with addr[1:0]!=0) SHALL go to DONE with err=1 and no bus cycle.
REQ-037 Macro LSU_MISALIGN_TRAP_EN undefined: H accesses SHALL ignore addr[0] and W accesses SHALL ignore addr[1:0]; a misaligned access SHALL never raise err.

Verification
REQ-038 LW addr=0x100, ack in the first ACCESS cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, wstrb=0000, rdata_out=0xDEADBEEF, load_ready 2 cycles after capture.
REQ-039 LB addr=0x103 with mem_rdata=0x80FF0000 -> rdata_out=0xFFFFFF80; LBU, same address and data -> 0x00000080.
REQ-040 SH addr=0x202, wdata=0x1234ABCD -> wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1, err=0.
REQ-041 LW with no ack, TIMEOUT_CYCLES=15 -> mem_req high for exactly 15 cycles, then err=1 with load_ready, rdata_out=0.
REQ-042 LH addr=0x301 -> with LSU_MISALIGN_TRAP_EN: err=1, mem_req never asserted; without it: bus access at 0x300 using the lower halfword.
REQ-043 Reset asserted in the second ACCESS cycle of a store -> mem_req=0 immediately, no load_ready, next request accepted normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store bus sequencer with lane steering, sign/zero extension and ack timeout.
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of aligning down.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        load_ready,
    output logic        busy,
    output logic [31:0] rdata_out,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        legal, misal, fault;
    logic [3:0]  strb;
    logic [31:0] wd, ld;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        legal = (funct3[1:0] != 2'b11) && (req_we ? !funct3[2] : (funct3[2:1] != 2'b11));
`ifdef LSU_MISALIGN_TRAP_EN
        misal = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        fault = !legal || misal;
        strb = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
               funct3[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
        wd = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
             funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        b = lo == 2'd0 ? mem_rdata[7:0] : lo == 2'd1 ? mem_rdata[15:8] :
            lo == 2'd2 ? mem_rdata[23:16] : mem_rdata[31:24];
        h = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld = f3 == 3'b000 ? {{24{b[7]}}, b} :
             f3 == 3'b001 ? {{16{h[15]}}, h} :
             f3 == 3'b100 ? {24'd0, b} :
             f3 == 3'b101 ? {16'd0, h} : mem_rdata;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            f3         <= '0;
            lo         <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            load_ready <= 1'b0;
            busy       <= 1'b0;
            rdata_out  <= '0;
            err        <= 1'b0;
        end else begin
            load_ready <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    f3   <= funct3;
                    lo   <= addr[1:0];
                    busy <= 1'b1;
                    if (fault) begin
                        state      <= DONE;
                        load_ready <= 1'b1;
                        err        <= 1'b1;
                    end else begin
                        state     <= ACCESS;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wstrb <= req_we ? strb : 4'b0000;
                        mem_wdata <= req_we ? wd : 32'd0;
                    end
                end
                ACCESS: begin
                    // ack on the limit cycle still completes normally
                    if (mem_ack || cnt + 8'd1 == LIMIT) begin
                        state      <= DONE;
                        load_ready <= 1'b1;
                        err        <= !mem_ack;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_wstrb  <= '0;
                        mem_wdata  <= '0;
                        if (!mem_we) rdata_out <= mem_ack ? ld : 32'd0;
                    end
                    if (!mem_ack) cnt <= cnt + 8'd1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized transactions against a transaction-level model, checked every cycle.
module tb_lsu_ctrl;
    localparam int TO = 15;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 0, reset = 1, req_valid = 0, req_we = 0, mem_ack = 0;
    logic [2:0] funct3 = 0;
    logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
    logic mem_req, mem_we, load_ready, busy, err;
    logic [31:0] mem_addr, mem_wdata, rdata_out;
    logic [3:0] mem_wstrb;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .load_ready(load_ready), .busy(busy), .rdata_out(rdata_out), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit chk_en = 0;
    logic e_req = 0, e_busy = 0, e_ready = 0, e_err = 0, e_we = 0;
    logic [31:0] e_rdata = 0, e_addr = 0, e_wdata = 0;
    logic [3:0] e_strb = 0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_strb;
    logic s_we, s_err;
    int req_cnt = 0, c_ready = 0, c_req = 0;
    logic r_we;
    logic [2:0] r_f;
    logic [31:0] r_a;
    int r_d, r_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", mem_req, e_req);
            chk("busy", busy, e_busy);
            chk("load_ready", load_ready, e_ready);
            chk("err", err, e_err);
            chk("rdata_out", rdata_out, e_rdata);
            if (e_req) begin
                chk("mem_we", mem_we, e_we);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", mem_wstrb, e_strb);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
        if (mem_req) begin
            req_cnt++;
            s_addr = mem_addr; s_wdata = mem_wdata; s_strb = mem_wstrb; s_we = mem_we;
        end
        if (load_ready) begin
            c_ready = cyc;
            s_err = err;
        end
    end

    function automatic logic [31:0] ld_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
        int b, h;
        b = int'((rd >> (8 * a[1:0])) & 32'hFF);
        h = int'((rd >> (16 * a[1])) & 32'hFFFF);
        case (f)
            3'b000: return b >= 128 ? b - 256 : b;
            3'b001: return h >= 32768 ? h - 65536 : h;
            3'b100: return b;
            3'b101: return h;
            default: return rd;
        endcase
    endfunction

    function automatic bit ok_model(input bit we, input logic [2:0] f, input logic [31:0] a);
        bit legal = we ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
        bit mis = TRAP && ((f[1:0] == 1 && a[0]) || (f[1:0] == 2 && a[1:0] != 0));
        return legal && !mis;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_req = 0; e_busy = 0; e_ready = 0; e_err = 0;
    endtask

    task automatic idle_cyc();
        step();
        req_valid = 0;
        mem_ack = 1'($urandom % 2);
        set_idle();
    endtask

    // d = ACCESS cycle carrying the ack (1-based), 0 = never acked
    task automatic txn(input bit we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input int d, input logic [31:0] rd);
        bit ok = ok_model(we, f, a);
        int n = ok ? (d == 0 ? TO : d) : 0;
        step();
        req_valid = 1; req_we = we; funct3 = f; addr = a; wdata = wd;
        mem_ack = 1'($urandom % 2);
        c_req = cyc;
        set_idle();
        for (int k = 1; k <= n; k++) begin
            step();
            mem_ack = (k == d);
            mem_rdata = (k == d) ? rd : $urandom;
            e_req = 1; e_busy = 1; e_ready = 0; e_err = 0; e_we = we;
            e_addr = a & ~32'd3;
            e_strb = !we ? 4'd0 : f == 0 ? 4'(1 << (a % 4)) : f == 1 ? (a[1] ? 4'd12 : 4'd3) : 4'd15;
            e_wdata = f == 0 ? wd[7:0] * 32'h01010101 : f == 1 ? wd[15:0] * 32'h00010001 : wd;
        end
        step();
        mem_ack = 1'($urandom % 2);
        mem_rdata = $urandom;
        e_req = 0; e_busy = 1; e_ready = 1;
        e_err = !ok || d == 0;
        if (ok && !we) e_rdata = d == 0 ? 32'd0 : ld_model(f, a, rd);
    endtask

    initial begin
        #12;
        chk("reset_mem_req", mem_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_load_ready", load_ready, 0);
        chk("reset_rdata_out", rdata_out, 0);
        chk("reset_err", err, 0);
        step();
        reset = 0;
        set_idle();
        chk_en = 1;
        idle_cyc();

        req_cnt = 0;
        txn(0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF);
        idle_cyc();
        chk("lw_rdata", rdata_out, 32'hDEADBEEF);
        chk("lw_addr", s_addr, 32'h100);
        chk("lw_wstrb", s_strb, 4'b0000);
        chk("lw_latency", c_ready - c_req, 2);

        txn(0, 3'b000, 32'h103, 0, 2, 32'h80FF0000);
        idle_cyc();
        chk("lb_rdata", rdata_out, 32'hFFFFFF80);
        txn(0, 3'b100, 32'h103, 0, 1, 32'h80FF0000);
        idle_cyc();
        chk("lbu_rdata", rdata_out, 32'h00000080);

        txn(1, 3'b001, 32'h202, 32'h1234ABCD, 2, 0);
        idle_cyc();
        chk("sh_wstrb", s_strb, 4'b1100);
        chk("sh_wdata", s_wdata, 32'hABCDABCD);
        chk("sh_we", s_we, 1);
        chk("sh_err", s_err, 0);

        req_cnt = 0;
        txn(0, 3'b010, 32'h104, 0, 0, 0);
        idle_cyc();
        chk("timeout_req_cycles", req_cnt, 15);
        chk("timeout_err", s_err, 1);
        chk("timeout_rdata", rdata_out, 0);

        txn(0, 3'b010, 32'h108, 0, TO, 32'h13579BDF);
        idle_cyc();
        chk("ack_at_limit_err", s_err, 0);
        chk("ack_at_limit_rdata", rdata_out, 32'h13579BDF);

        req_cnt = 0;
        txn(0, 3'b001, 32'h301, 0, 1, 32'h12348001);
        idle_cyc();
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_mis_err", s_err, 1);
        chk("lh_mis_no_bus", req_cnt, 0);
`else
        chk("lh_mis_err", s_err, 0);
        chk("lh_mis_addr", s_addr, 32'h300);
        chk("lh_mis_rdata", rdata_out, 32'hFFFF8001);
`endif

        req_cnt = 0;
        txn(1, 3'b100, 32'h40, 32'h55, 1, 0);
        idle_cyc();
        chk("illegal_store_err", s_err, 1);
        chk("illegal_store_no_bus", req_cnt, 0);

        c_ready = 0;
        step();
        req_valid = 1; req_we = 1; funct3 = 3'b010; addr = 32'h400; wdata = 32'hCAFEF00D; mem_ack = 0;
        set_idle();
        for (int k = 0; k < 2; k++) begin
            step();
            e_req = 1; e_busy = 1; e_we = 1; e_addr = 32'h400; e_strb = 4'hF; e_wdata = 32'hCAFEF00D;
        end
        #2 reset = 1;
        #1;
        chk("reset_drops_mem_req", mem_req, 0);
        set_idle();
        e_rdata = 0;
        step();
        reset = 0;
        req_valid = 0;
        repeat (4) idle_cyc();
        chk("reset_no_load_ready", c_ready, 0);
        txn(0, 3'b101, 32'h502, 0, 3, 32'h9ABC1234);
        idle_cyc();
        chk("after_reset_rdata", rdata_out, 32'h00009ABC);

        for (int i = 0; i < 300; i++) begin
            r_we = 1'($urandom % 2);
            r_f = 3'($urandom_range(0, 7));
            r_a = $urandom;
            r_sel = $urandom_range(0, 19);
            r_d = r_sel == 0 ? 0 : r_sel == 1 ? TO : $urandom_range(1, 3);
            txn(r_we, r_f, r_a, $urandom, r_d, $urandom);
            repeat ($urandom_range(0, 2)) idle_cyc();
        end
        idle_cyc();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
